// File: rtl/debug_regfile_dump_sequencer.sv
// Purpose: walks every register address through the debug register-file
// controller, captures each 32-bit frame and streams it MSB-first, one byte
// at a time, to the UART transmitter. Timeouts on either handshake abort the
// dump and raise a sticky error flag.
//
// Ports:
//   i_clock, i_reset    clock, synchronous active-high reset
//   i_start             one-cycle pulse that begins a dump (ignored while busy)
//   o_request_select    {~req, addr[4:0]} to the controller; 6'b100000 = idle
//   i_writing, i_frame  controller write window and frame data
//   o_tx_data           byte presented to the UART
//   o_tx_start          one-cycle pulse: transmit o_tx_data
//   i_tx_done           one-cycle pulse: byte transmitted
//   o_busy              dump in progress
//   o_done              one-cycle pulse: dump completed normally
//   o_error             sticky timeout flag (cleared by reset or next start)
module debug_regfile_dump_sequencer #(
   parameter int unsigned NB_CONTROL_FRAME = 32,
   parameter int unsigned NB_TX_DATA       = 8,
   parameter int unsigned N_REGS           = 32,
   parameter int unsigned NB_TIMEOUT       = 8,
   parameter int unsigned TIMEOUT_CYCLES   = 200
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_start,
   output logic [5:0]                  o_request_select,
   input  logic                        i_writing,
   input  logic [NB_CONTROL_FRAME-1:0] i_frame,
   output logic [NB_TX_DATA-1:0]       o_tx_data,
   output logic                        o_tx_start,
   input  logic                        i_tx_done,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_error
);

   localparam int unsigned NB_REQ      = 6;
   localparam int unsigned NB_ADDR     = 5;
   localparam int unsigned N_BYTES     = NB_CONTROL_FRAME / NB_TX_DATA;
   localparam int unsigned NB_BYTE_IDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

   localparam logic [NB_REQ-1:0]      REQ_IDLE  = 6'b100000;
   localparam logic [NB_BYTE_IDX-1:0] LAST_BYTE = NB_BYTE_IDX'(N_BYTES - 1);
   localparam logic [NB_ADDR-1:0]     LAST_ADDR = NB_ADDR'(N_REGS - 1);
   localparam logic [NB_TIMEOUT-1:0]  WD_LIMIT  = NB_TIMEOUT'(TIMEOUT_CYCLES);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_SEND,
      ST_WAIT_TX,
      ST_NEXT,
      ST_DONE,
      ST_ABORT
   } state_t;

   state_t                      state, state_next;
   logic [NB_ADDR-1:0]          addr, addr_next, addr_inc;
   logic [NB_BYTE_IDX-1:0]      byte_idx, byte_idx_next;
   logic [NB_TIMEOUT-1:0]       watchdog, watchdog_next, watchdog_inc;
   logic [NB_CONTROL_FRAME-1:0] shift, shift_next;
   logic [NB_REQ-1:0]           req_sel_next;
   logic [NB_TX_DATA-1:0]       tx_data_next;
   logic                        tx_start_next, busy_next, done_next, error_next;

   // State and all output/datapath registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state            <= ST_IDLE;
         addr             <= '0;
         byte_idx         <= '0;
         watchdog         <= '0;
         shift            <= '0;
         o_request_select <= REQ_IDLE;
         o_tx_data        <= '0;
         o_tx_start       <= 1'b0;
         o_busy           <= 1'b0;
         o_done           <= 1'b0;
         o_error          <= 1'b0;
      end else begin
         state            <= state_next;
         addr             <= addr_next;
         byte_idx         <= byte_idx_next;
         watchdog         <= watchdog_next;
         shift            <= shift_next;
         o_request_select <= req_sel_next;
         o_tx_data        <= tx_data_next;
         o_tx_start       <= tx_start_next;
         o_busy           <= busy_next;
         o_done           <= done_next;
         o_error          <= error_next;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_next    = state;
      addr_next     = addr;
      byte_idx_next = byte_idx;
      watchdog_next = watchdog;
      shift_next    = shift;
      req_sel_next  = o_request_select;
      tx_data_next  = o_tx_data;
      tx_start_next = 1'b0;
      busy_next     = o_busy;
      done_next     = 1'b0;
      error_next    = o_error;
      addr_inc      = addr + NB_ADDR'(1);
      // Saturating so a stuck handshake can never wrap back below the limit
      watchdog_inc  = (watchdog == '1) ? watchdog : watchdog + NB_TIMEOUT'(1);

      case (state)
         ST_IDLE: begin
            if (i_start) begin
               addr_next    = '0;
               error_next   = 1'b0;
               busy_next    = 1'b1;
               // Request is loaded on the transition so it appears one cycle after start
               req_sel_next = {1'b0, NB_ADDR'(0)};
               state_next   = ST_REQ;
            end
         end
         ST_REQ: begin
            watchdog_next = '0;
            state_next    = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (i_writing)                state_next    = ST_WAIT_LO;
            else if (watchdog == WD_LIMIT) state_next    = ST_ABORT;
            else                          watchdog_next = watchdog_inc;
         end
         ST_WAIT_LO: begin
            // Falling edge of the write window: frame is complete; dropping to the
            // idle code re-arms the controller's request edge detector
            if (!i_writing) begin
               shift_next    = i_frame;
               req_sel_next  = REQ_IDLE;
               byte_idx_next = '0;
               state_next    = ST_SEND;
            end
         end
         ST_SEND: begin
            tx_data_next  = shift[NB_CONTROL_FRAME-1 -: NB_TX_DATA];
            tx_start_next = 1'b1;
            watchdog_next = '0;
            state_next    = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (i_tx_done) begin
               shift_next    = shift << NB_TX_DATA;
               byte_idx_next = byte_idx + NB_BYTE_IDX'(1);
               state_next    = (byte_idx == LAST_BYTE) ? ST_NEXT : ST_SEND;
            end else if (watchdog == WD_LIMIT) begin
               state_next = ST_ABORT;
            end else begin
               watchdog_next = watchdog_inc;
            end
         end
         ST_NEXT: begin
            if (addr == LAST_ADDR) begin
               state_next = ST_DONE;
            end else begin
               addr_next    = addr_inc;
               req_sel_next = {1'b0, addr_inc};
               state_next   = ST_REQ;
            end
         end
         ST_DONE: begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
         end
         ST_ABORT: begin
            error_next   = 1'b1;
            req_sel_next = REQ_IDLE;
            busy_next    = 1'b0;
            state_next   = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule
